weight_stream_scheduler: RTL
============================

# weight_stream_scheduler

Sequences reads from a 2-cycle-latency parameter ROM (the `*_weight` ROM wrapper: `address0`/`ce0`/`q0`) and presents the words as a proper valid/ready stream for the linear/attention datapath. Replays the full weight tensor a programmable number of passes, once per input row. Tracks ROM read latency with an in-flight counter and a 4-entry show-ahead FIFO, so back-pressure never drops or duplicates a word. Replaces the free-running counter-plus-`valid=1` weight source wherever the consumer can stall.

## Interface

Parameters:

- `DATA_WIDTH`, 128: ROM word width; equals `WEIGHT_PRECISION_0 * WEIGHT_PARALLELISM`.
- `OUT_DEPTH`, 576: words per pass (ROM addresses `0..OUT_DEPTH-1`).
- `ADDR_WIDTH`, `$clog2(OUT_DEPTH)+1`: ROM address width.
- `PASS_WIDTH`, 16: width of the pass count.

Ports:

- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle request to begin a run; sampled only in IDLE.
- `num_passes`, in, `PASS_WIDTH`: number of full tensor passes; sampled with `start`.
- `abort`, in, 1: synchronous flush back to IDLE.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse when a run completes.
- `rom_addr`, out, `ADDR_WIDTH`: drives ROM `address0`.
- `rom_ce`, out, 1: drives ROM `ce0`; constant 1.
- `rom_q`, in, `DATA_WIDTH`: ROM `q0`.
- `data_out`, out, `DATA_WIDTH`: FIFO head word.
- `data_out_valid`, out, 1: head word valid.
- `data_out_ready`, in, 1: consumer accepts when valid & ready.
- `data_out_last_row`, out, 1: head word is address `OUT_DEPTH-1`.
- `data_out_last`, out, 1: head word is the final word of the run.

## Operation

- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE:**
  - On `start` with `num_passes != 0`: latch `num_passes`, clear the address and pass counters, go to RUN.
  - On `start` with `num_passes == 0`: pulse `done` next cycle and stay in IDLE.
- **Issue rule (RUN only):** issue a read when `fifo_count + inflight < 4`.
  - Each issue presents `rom_addr` and pushes a tag `{last_row, last}` into a 2-stage tag pipeline matching the ROM latency.
- **Counters:**
  - The address counter wraps `OUT_DEPTH-1 -> 0` and increments the pass counter.
  - Issuing address `OUT_DEPTH-1` in pass `num_passes-1` moves RUN to DRAIN.
- **DRAIN:** no issues. When `inflight == 0` and the FIFO is empty, pulse `done` and go to IDLE.
- **`inflight`** is 0..2: +1 per issue, -1 when a tagged word lands in the FIFO. Both in the same cycle means no change.
- **FIFO:** 4 entries of `DATA_WIDTH+2` bits, show-ahead.
  - Write occurs when a tagged word arrives.
  - Read occurs on `data_out_valid & data_out_ready`.
  - Simultaneous read and write keeps the count unchanged.
  - The issue rule guarantees the FIFO never overflows.
- **Output hold:** `data_out`, `data_out_valid` and both last flags hold stable while `valid & !ready`.
- **`start` while busy** is ignored.
- **`abort`** (any state, priority over everything):
  - Next cycle the FIFO and `inflight` are cleared, the tag pipeline is invalidated and the FSM is in IDLE.
  - No `done` pulse.
  - ROM words still in flight are discarded.
- **Reset values (while `rst` low):** state IDLE, `busy=0`, `done=0`, `rom_addr=0`, `data_out_valid=0`, `data_out_last_row=0`, `data_out_last=0`, `data_out=0`, counters 0. `rom_ce` stays 1.
- **Reset mid-run** behaves like abort, asynchronously.

## Timing

- `start` is sampled at edge E0. RUN and `busy` are high in cycle 1, and the first `rom_addr=0` is presented in cycle 1.
- ROM word for an address presented in cycle t is on `rom_q` in cycle t+2 and written into the FIFO at the end of t+2. `data_out_valid` rises in cycle t+3, so the first beat is valid in cycle 4.
- With `data_out_ready` held at 1: one beat per cycle with no bubbles. A run takes `num_passes*OUT_DEPTH + 3` cycles from `start` to the final beat. `done` is asserted in the cycle after the final handshake.
- On back-pressure, issue stops within 1 cycle and at most 4 words are buffered. After ready returns, the next beat comes out in the same cycle.
- `busy` falls in the same cycle `done` pulses.

## Configuration

- **`WEIGHT_STREAM_PERF_CNT_EN`**
  - Defined: adds output `stall_cycles [31:0]`, which counts cycles with `data_out_valid & !data_out_ready` while busy. It clears on `start`, saturates at `32'hFFFFFFFF`, resets to 0 and holds its value after `done`.
  - Undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan

- **Single pass, no back-pressure.** `OUT_DEPTH=8`, `num_passes=1`, ready=1 -> words 0..7 on consecutive cycles 4..11. `last_row` and `last` are set only on word 7. `done` at cycle 12.
- **Multiple passes.** `num_passes=3`, `OUT_DEPTH=8` -> 24 beats, address sequence wraps 7->0. `last_row` on beats 8, 16 and 24. `last` only on beat 24.
- **Random back-pressure.** Ready toggled pseudo-randomly at 50% -> output sequence exactly matches the ROM contents in order, with no drops or duplicates. `fifo_count` never exceeds 4. Data holds stable while stalled.
- **Zero passes and busy start.** `start` with `num_passes=0` -> `done` the next cycle with no valid beats. A second `start` during RUN is ignored.
- **Abort.** Abort in cycle 6 of a 2-pass run, with ready=0 from cycle 4 -> IDLE, `valid=0` and no `done` next cycle. A following run starts cleanly at address 0.
- **Perf counter and async reset.** With `WEIGHT_STREAM_PERF_CNT_EN` and ready=0 for 10 busy cycles with valid high -> `stall_cycles=10`. Asserting `rst` low mid-run -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/weight_stream_scheduler.sv
// Streams a 2-cycle-latency weight ROM as a valid/ready stream, replaying the tensor num_passes times.
// Optional stall counter output enabled by defining WEIGHT_STREAM_PERF_CNT_EN.
module weight_stream_scheduler #(
    parameter int DATA_WIDTH = 128,
    parameter int OUT_DEPTH  = 576,
    parameter int ADDR_WIDTH = $clog2(OUT_DEPTH) + 1,
    parameter int PASS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_out_last_row,
    output logic                  data_out_last
`ifdef WEIGHT_STREAM_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam int STAGES = 1;  // ROM latency minus one

    typedef struct packed {
        logic last_row;
        logic last;
    } tag_t;

    typedef struct packed {
        tag_t                  tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [PASS_WIDTH-1:0] pass_cnt, passes_q;
    logic [1:0]            inflight, inflight_nxt;
    logic [2:0]            fifo_count, fifo_count_nxt;
    logic [1:0]            wr_ptr, rd_ptr;
    logic [STAGES:0]       vld_pipe;
    tag_t [STAGES:0]       tag_pipe;
    entry_t                mem [4];
    entry_t                head;
    tag_t                  issue_tag;
    logic                  issue, fifo_wr, fifo_rd, addr_last, pass_last, drain_done;

    // fifo_count + inflight < 4 reserves a FIFO slot for every word already requested
    assign issue     = (state == RUN) && (({1'b0, fifo_count} + {2'b00, inflight}) < 4'd4);
    assign addr_last = (addr_cnt == ADDR_WIDTH'(OUT_DEPTH - 1));
    assign pass_last = (pass_cnt == passes_q - PASS_WIDTH'(1));
    assign issue_tag = '{last_row: addr_last, last: addr_last && pass_last};
    assign fifo_wr   = vld_pipe[STAGES];
    assign fifo_rd   = data_out_valid && data_out_ready;

    always_comb begin
        fifo_count_nxt = fifo_count;
        if (fifo_wr && !fifo_rd)
            fifo_count_nxt = fifo_count + 3'd1;
        else if (!fifo_wr && fifo_rd)
            fifo_count_nxt = fifo_count - 3'd1;
        inflight_nxt = inflight;
        if (issue && !fifo_wr)
            inflight_nxt = inflight + 2'd1;
        else if (!issue && fifo_wr)
            inflight_nxt = inflight - 2'd1;
    end

    // Decide completion on next-cycle occupancy so done and busy-low land the cycle after the last beat
    assign drain_done = (state == DRAIN) && (inflight_nxt == 2'd0) && (fifo_count_nxt == 3'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            addr_cnt   <= '0;
            pass_cnt   <= '0;
            passes_q   <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            vld_pipe   <= '0;
            tag_pipe   <= '0;
        end else if (abort) begin
            state      <= IDLE;
            done       <= 1'b0;
            addr_cnt   <= '0;
            pass_cnt   <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            vld_pipe   <= '0;
        end else begin
            done       <= 1'b0;
            vld_pipe   <= {vld_pipe[STAGES-1:0], issue};
            tag_pipe   <= {tag_pipe[STAGES-1:0], issue_tag};
            inflight   <= inflight_nxt;
            fifo_count <= fifo_count_nxt;
            if (fifo_wr) wr_ptr <= wr_ptr + 2'd1;
            if (fifo_rd) rd_ptr <= rd_ptr + 2'd1;
            case (state)
                IDLE: if (start) begin
                    if (num_passes != '0) begin
                        passes_q <= num_passes;
                        addr_cnt <= '0;
                        pass_cnt <= '0;
                        state    <= RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end
                RUN: if (issue) begin
                    if (addr_last) begin
                        addr_cnt <= '0;
                        pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                        if (pass_last) state <= DRAIN;
                    end else begin
                        addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: if (drain_done) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= '{tag: tag_pipe[STAGES], data: rom_q};
    end

    assign head              = mem[rd_ptr];
    assign busy              = (state == RUN) || (state == DRAIN);
    assign rom_addr          = addr_cnt;
    assign rom_ce            = 1'b1;
    assign data_out_valid    = (fifo_count != 3'd0);
    // Gate on valid so the head reads zero whenever the FIFO is empty, including out of reset
    assign data_out          = data_out_valid ? head.data : '0;
    assign data_out_last_row = data_out_valid && head.tag.last_row;
    assign data_out_last     = data_out_valid && head.tag.last;

`ifdef WEIGHT_STREAM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if (!abort && state == IDLE && start)
            stall_cycles <= '0;
        else if (busy && data_out_valid && !data_out_ready && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
